counter_checker: RTL

Synthesizable on-chip self-check for a free-running WIDTH-bit LED counter. It observes the counter value, locks on to the count sequence, predicts each next value mod 2^WIDTH and counts mismatches. After TARGET_STEPS tracked samples it reports a sticky pass/fail, so hardware runs are checked the same way simulation checks the counter.

---
 rtl/counter_checker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - self-check for a free-running LED counter: lock, predict, count mismatches, sticky verdict
// Locks after LOCK_COUNT consecutive successors, then tracks TARGET_STEPS samples before pass/fail.
module counter_checker #(
  parameter int WIDTH        = 4,
  parameter int LOCK_COUNT   = 3,
  parameter int TARGET_STEPS = 63,
  parameter int ERR_W        = 8,
  parameter int MAX_ERR      = 255,
  localparam int STEP_W      = $clog2(TARGET_STEPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic              locked,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_count,
  output logic [STEP_W-1:0] step_count,
  output logic              pass,
  output logic              fail
);

  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    S_ACQUIRE = 2'd0,
    S_TRACK   = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               mismatch_q, mismatch_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ACQUIRE;
      run_q      <= '0;
      prev_q     <= '0;
      expected_q <= '0;
      err_q      <= '0;
      step_q     <= '0;
      mismatch_q <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      prev_q     <= prev_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      step_q     <= step_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    prev_d     = prev_q;
    expected_d = expected_q;
    err_d      = err_q;
    step_d     = step_q;
    mismatch_d = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    case (state_q)
      S_ACQUIRE: begin
        if (sample_en) begin
          if (run_q == '0 || cnt_in != prev_q + 1'b1) run_d = RUN_W'(1);
          else                                        run_d = run_q + 1'b1;
          prev_d = cnt_in;
          if (run_d == RUN_W'(LOCK_COUNT)) begin
            state_d    = S_TRACK;
            expected_d = cnt_in + 1'b1;
          end
        end
      end
      S_TRACK: begin
        if (sample_en) begin
          step_d = step_q + 1'b1;
          if (cnt_in == expected_q) begin
            expected_d = expected_q + 1'b1;
          end else begin
            // Resync on the observed value so one discontinuity costs one error.
            mismatch_d = 1'b1;
            expected_d = cnt_in + 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          if (err_d >= ERR_W'(MAX_ERR)) begin
            state_d = S_DONE;
            fail_d  = 1'b1;
          end else if (step_d == STEP_W'(TARGET_STEPS)) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0);
            fail_d  = (err_d != '0);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    locked     = (state_q != S_ACQUIRE);
    mismatch   = mismatch_q;
    err_count  = err_q;
    step_count = step_q;
    pass       = pass_q;
    fail       = fail_q;
  end

endmodule
